// File: rtl/argmax_8_16.sv
// argmax_8_16: streaming argmax over M-word vectors of signed T-bit samples.
// Accepts one word per input handshake, tracks the running maximum and its
// index, and presents {out_idx, out_max} once per vector via a valid/ready
// output handshake. Ties resolve to the lowest index.
module argmax_8_16 #(
  parameter int T  = 16,
  parameter int M  = 8,
  parameter int IW = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [T-1:0]  data_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [IW-1:0] out_idx,
  output logic [T-1:0]  out_max
);

  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t                state;
  logic [IW-1:0]         cnt;
  logic [IW-1:0]         run_idx;
  logic signed [T-1:0]   run_max;

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  first;
  logic                  last;
  logic                  take;
  logic [IW-1:0]         next_idx;
  logic signed [T-1:0]   next_max;

  // Ready is the only combinational output: free in COLLECT, or in HOLD when
  // the pending result leaves on the same edge.
  always_comb begin
    s_ready  = !reset && (state == COLLECT || m_ready);
    in_xfer  = s_valid && s_ready;
    out_xfer = m_valid && m_ready;
  end

  // Running max/idx including the word currently on data_in.
  always_comb begin
    first    = (cnt == '0);
    last     = (cnt == LAST_IDX);
    take     = first || ($signed(data_in) > run_max);
    next_max = take ? $signed(data_in) : run_max;
    next_idx = first ? '0 : (take ? cnt : run_idx);
  end

  // Controller: element counter, running state and registered result.
  // An input transfer in HOLD can only happen together with an output
  // transfer, so the input branch is allowed to override the return to COLLECT
  // (re-entering HOLD directly when the new word also completes a vector).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= COLLECT;
      cnt     <= '0;
      run_idx <= '0;
      run_max <= '0;
      m_valid <= 1'b0;
      out_idx <= '0;
      out_max <= '0;
    end else begin
      if (out_xfer) begin
        state   <= COLLECT;
        m_valid <= 1'b0;
      end
      if (in_xfer) begin
        run_max <= next_max;
        run_idx <= next_idx;
        if (last) begin
          cnt     <= '0;
          out_max <= next_max;
          out_idx <= next_idx;
          state   <= HOLD;
          m_valid <= 1'b1;
        end else begin
          cnt <= cnt + IW'(1);
        end
      end
    end
  end

endmodule

// File: doc/argmax_8_16.md
ARGMAX_8_16 -- requirements
Module: argmax_8_16

Interface
Parameters:
REQ-001 T, 16, data word width in bits (signed two's complement).
REQ-002 M, 8, vector length: number of consecutive input words forming one layer output vector.
REQ-003 IW, $clog2(M), index width.
Ports:
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 s_valid  input  1  upstream word valid (driven by layer_16_8_8_16 m_valid).
REQ-007 s_ready  output  1  block can accept data_in this cycle.
REQ-008 data_in  input  T  signed input word, element k of current vector.
REQ-009 m_valid  output  1  result available.
REQ-010 m_ready  input  1  downstream accepts result.
REQ-011 out_idx  output  IW  index (0..M-1) of maximum element of the vector.
REQ-012 out_max  output  T  signed value of that maximum element.

Function
REQ-013 Input transfer occurs on a rising edge with s_valid && s_ready; output transfer on a rising edge with m_valid && m_ready.
REQ-014 Two states: COLLECT (accumulating a vector) and HOLD (result presented).
REQ-015 Element counter cnt (0..M-1) increments on each input transfer and wraps to 0 after the M-th element of a vector.
REQ-016 On transfer with cnt==0, running max := data_in, running idx := 0.
REQ-017 On transfer with cnt>0, running max/idx update only if data_in > running max (signed strict compare); ties keep the lower index.
REQ-018 On transfer with cnt==M-1, final max/idx (including this element) load into out_max/out_idx and state goes to HOLD; m_valid asserts the following cycle (latency one cycle from last element).
REQ-019 In HOLD, m_valid=1 and out_idx/out_max stay stable until output transfer.
REQ-020 s_ready = !reset && (state==COLLECT || m_ready) — combinational; no input transfer in HOLD unless the result is consumed the same cycle.
REQ-021 HOLD with output and input transfers in the same edge: state returns to COLLECT, and the accepted word is element 0 of the next vector (running max/idx load, cnt=1).
REQ-022 HOLD with output transfer only: state returns to COLLECT, m_valid deasserts next cycle.
REQ-023 M==1 back-to-back: an input transfer in HOLD concurrent with output transfer re-enters HOLD with the new result; m_valid stays 1.
REQ-024 s_valid low mid-vector: running max/idx and cnt hold indefinitely; no timeout.
REQ-025 data_out values are never modified (no saturation); out_max equals a received word bit-exactly.
REQ-026 No combinational path from data_in to any output; only m_ready->s_ready is combinational.

Reset
REQ-027 While reset=1: state=COLLECT, cnt=0, m_valid=0, s_ready=0, out_idx=0, out_max=0, running max/idx=0.
REQ-028 Reset asserted mid-vector or in HOLD discards partial vector and pending result; first transfer after release is element 0.
REQ-029 Reset deassertion is used synchronously relative to clk for state-machine exit (first transfer possible on first rising edge after release).

Verification
REQ-030 Single vector {3,-1,7,7,2,0,-5,1}, m_ready=1 -> one result out_idx=2, out_max=0x0007, m_valid one cycle after 8th transfer.
REQ-031 All-negative vector {-9,-4,-4,-8,-100,-32768,-5,-6} -> out_idx=1, out_max=0xFFFC (signed compare, tie to lower index).
REQ-032 m_ready=0 for 20 cycles after result -> m_valid and outputs stable, s_ready=0, no data_in lost; then m_ready=1 with s_valid=1 -> result and next element 0 transfer on same edge.
REQ-033 Reset pulse after 5 elements of a vector, then full vector {0,0,0,0,0,0,0,32767} -> out_idx=7, out_max=0x7FFF, no stale result emitted.
REQ-034 Randomized s_valid/m_ready (50% each) over 2500 vectors fed by layer_16_8_8_16 output stream -> every result matches golden argmax file, result count = 2500.
